udma_ch_evt_decoder: RTL and testbench

//  Inverse of the uDMA channel map: turns per-channel end-of-transfer pulses back into peripheral events.

---
 rtl/udma_ch_evt_decoder_pkg.sv | 71 +++++++
 rtl/udma_evt_rr_pick.sv | 25 ++
 rtl/udma_ch_evt_decoder.sv | 109 ++++++++++
 tb/tb_udma_ch_evt_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/udma_ch_evt_decoder_pkg.sv
// udma_ch_evt_decoder_pkg: channel/peripheral map and channel-to-event translation
package udma_ch_evt_decoder_pkg;

    localparam int N_RX_LIN_CHANNELS = 12;
    localparam int N_TX_LIN_CHANNELS = 19;
    localparam int N_RX_EXT_CHANNELS = 1;
    localparam int N_EVT_SRC         = N_RX_LIN_CHANNELS + N_TX_LIN_CHANNELS + N_RX_EXT_CHANNELS;
    localparam int EVT_W             = 8;

    localparam int PER_ID_UART  = 0;
    localparam int PER_ID_QSPIM = 2;
    localparam int PER_ID_I2C   = 6;
    localparam int PER_ID_CPI   = 10;
    localparam int PER_ID_DVSI  = 11;
    localparam int PER_ID_HYPER = 12;

    localparam int CH_ID_RX_UART  = 0;
    localparam int CH_ID_RX_QSPIM = 2;
    localparam int CH_ID_RX_I2C   = 6;
    localparam int CH_ID_RX_CPI   = 10;
    localparam int CH_ID_RX_HYPER = 11;

    localparam int CH_ID_TX_UART   = 0;
    localparam int CH_ID_TX_QSPIM  = 2;
    localparam int CH_ID_CMD_QSPIM = 6;
    localparam int CH_ID_TX_I2C    = 10;
    localparam int CH_ID_CMD_I2C   = 14;
    localparam int CH_ID_TX_HYPER  = 18;

    // External RX channels below this index are filter channels with no event
    localparam int CH_ID_EXT_RX_DVSI = 0;

    typedef enum logic [1:0] {
        EVT_TYPE_RX  = 2'd0,
        EVT_TYPE_TX  = 2'd1,
        EVT_TYPE_CMD = 2'd2
    } evt_type_e;

    function automatic logic [EVT_W-1:0] mk_evt(int per, evt_type_e t);
        return EVT_W'(per * 4 + int'(t));
    endfunction

    function automatic logic [EVT_W-1:0] src_to_evt_id(int idx);
        int c;
        if (idx < N_RX_LIN_CHANNELS) begin
            c = idx;
            if (c < CH_ID_RX_QSPIM) return mk_evt(PER_ID_UART + c - CH_ID_RX_UART, EVT_TYPE_RX);
            if (c < CH_ID_RX_I2C)   return mk_evt(PER_ID_QSPIM + c - CH_ID_RX_QSPIM, EVT_TYPE_RX);
            if (c < CH_ID_RX_CPI)   return mk_evt(PER_ID_I2C + c - CH_ID_RX_I2C, EVT_TYPE_RX);
            if (c < CH_ID_RX_HYPER) return mk_evt(PER_ID_CPI + c - CH_ID_RX_CPI, EVT_TYPE_RX);
            return mk_evt(PER_ID_HYPER + c - CH_ID_RX_HYPER, EVT_TYPE_RX);
        end
        if (idx < N_RX_LIN_CHANNELS + N_TX_LIN_CHANNELS) begin
            c = idx - N_RX_LIN_CHANNELS;
            if (c < CH_ID_TX_QSPIM)  return mk_evt(PER_ID_UART + c - CH_ID_TX_UART, EVT_TYPE_TX);
            if (c < CH_ID_CMD_QSPIM) return mk_evt(PER_ID_QSPIM + c - CH_ID_TX_QSPIM, EVT_TYPE_TX);
            if (c < CH_ID_TX_I2C)    return mk_evt(PER_ID_QSPIM + c - CH_ID_CMD_QSPIM, EVT_TYPE_CMD);
            if (c < CH_ID_CMD_I2C)   return mk_evt(PER_ID_I2C + c - CH_ID_TX_I2C, EVT_TYPE_TX);
            if (c < CH_ID_TX_HYPER)  return mk_evt(PER_ID_I2C + c - CH_ID_CMD_I2C, EVT_TYPE_CMD);
            return mk_evt(PER_ID_HYPER + c - CH_ID_TX_HYPER, EVT_TYPE_TX);
        end
        c = idx - N_RX_LIN_CHANNELS - N_TX_LIN_CHANNELS;
        return mk_evt(PER_ID_DVSI + c - CH_ID_EXT_RX_DVSI, EVT_TYPE_RX);
    endfunction

    function automatic logic src_raises_evt(int idx);
        return (idx < N_RX_LIN_CHANNELS + N_TX_LIN_CHANNELS) ||
               (idx - N_RX_LIN_CHANNELS - N_TX_LIN_CHANNELS >= CH_ID_EXT_RX_DVSI);
    endfunction

endpackage

// File: rtl/udma_evt_rr_pick.sv
// udma_evt_rr_pick: combinational round-robin pick, first request at or above ptr with wrap
module udma_evt_rr_pick #(
    parameter int N = 32,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         gnt_valid_o,
    output logic [W-1:0] gnt_idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) if (rot[i]) off = W'(i);
        gnt_valid_o = |req_i;
        gnt_idx_o   = W'((int'(ptr_i) + int'(off)) % N);
    end

endmodule

// File: rtl/udma_ch_evt_decoder.sv
// udma_ch_evt_decoder: turns uDMA channel done pulses into round-robin arbitrated peripheral events
module udma_ch_evt_decoder
    import udma_ch_evt_decoder_pkg::*;
#(
    parameter int N_RX_LIN = N_RX_LIN_CHANNELS,
    parameter int N_TX_LIN = N_TX_LIN_CHANNELS,
    parameter int N_RX_EXT = N_RX_EXT_CHANNELS,
    parameter int EVT_W    = 8,
    parameter int DROP_W   = 8,
    localparam int N_SRC   = N_RX_LIN + N_TX_LIN + N_RX_EXT,
    localparam int SRC_W   = $clog2(N_SRC)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_RX_LIN-1:0] rx_lin_done_i,
    input  logic [N_TX_LIN-1:0] tx_lin_done_i,
    input  logic [N_RX_EXT-1:0] rx_ext_done_i,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic [EVT_W-1:0]    evt_id_o,
    output logic [SRC_W-1:0]    evt_src_o,
    output logic                ovf_o,
    output logic [SRC_W-1:0]    ovf_src_o,
    output logic [DROP_W-1:0]   drop_cnt_o,
    input  logic                ovf_clr_i
);

    localparam int CNT_W = $clog2(N_SRC + 1);
    localparam int SUM_W = DROP_W + 1;

    logic [N_SRC-1:0]  evt_mask, pulse, clr_vec, hits, pend_q, pend_d;
    logic [EVT_W-1:0]  id_lut [N_SRC];
    logic              gnt_valid, load, take, ovf_keep;
    logic [SRC_W-1:0]  gnt_idx, hit_lo;
    logic [CNT_W-1:0]  hit_n;
    logic [SUM_W-1:0]  cnt_sum;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic [EVT_W-1:0]  id_q, id_d;
    logic [SRC_W-1:0]  src_q, src_d, ptr_q, ptr_d, ovf_src_q, ovf_src_d;
    logic [DROP_W-1:0] cnt_q, cnt_d;

    genvar g;
    for (g = 0; g < N_SRC; g++) begin : g_map
        assign id_lut[g]   = EVT_W'(src_to_evt_id(g));
        assign evt_mask[g] = src_raises_evt(g);
    end

    udma_evt_rr_pick #(.N(N_SRC)) u_pick (
        .req_i       (pend_q),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        pulse   = {rx_ext_done_i, tx_lin_done_i, rx_lin_done_i} & evt_mask;
        load    = !valid_q || evt_ready_i;
        take    = load && gnt_valid;
        clr_vec = take ? (N_SRC'(1) << gnt_idx) : '0;
        // A pulse on a bit being granted this cycle re-arms it instead of overflowing
        hits    = pulse & pend_q & ~clr_vec;
        pend_d  = (pend_q & ~clr_vec) | pulse;
        hit_n   = '0;
        hit_lo  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            hit_n = hit_n + CNT_W'(hits[i]);
            if (hits[i]) hit_lo = SRC_W'(i);
        end
        ovf_keep  = ovf_q && !ovf_clr_i;
        cnt_sum   = (ovf_clr_i ? '0 : {1'b0, cnt_q}) + SUM_W'(hit_n);
        cnt_d     = cnt_sum[DROP_W] ? '1 : cnt_sum[DROP_W-1:0];
        ovf_d     = ovf_keep || (hits != '0);
        ovf_src_d = ovf_keep ? ovf_src_q : (hits != '0) ? hit_lo : '0;
        valid_d   = load ? gnt_valid : valid_q;
        id_d      = take ? id_lut[gnt_idx] : id_q;
        src_d     = take ? gnt_idx : src_q;
        ptr_d     = !take ? ptr_q : (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            src_q     <= '0;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
            ovf_src_q <= '0;
            cnt_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            ovf_src_q <= ovf_src_d;
            cnt_q     <= cnt_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign evt_src_o   = src_q;
    assign ovf_o       = ovf_q;
    assign ovf_src_o   = ovf_src_q;
    assign drop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_udma_ch_evt_decoder.sv
// tb_udma_ch_evt_decoder: table vectors, corner sequences and random traffic against a reference model
module tb_udma_ch_evt_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pv  = '0;
    logic        rdy = 1'b0;
    logic        clr = 1'b0;
    logic        evt_valid, ovf;
    logic [7:0]  evt_id, drop_cnt;
    logic [4:0]  evt_src, ovf_src;

    int n_chk = 0;
    int n_fail = 0;

    // Event IDs per flattened source, derived by hand from the peripheral map
    int exp_ids [32] = '{0, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 48,
                         1, 5, 9, 13, 17, 21, 10, 14, 18, 22, 25, 29, 33, 37, 26, 30, 34, 38, 49,
                         44};

    bit [31:0] m_pend;
    bit        m_v, m_ovf;
    int        m_src, m_ptr, m_osrc, m_cnt;

    typedef struct {
        int bitpos;
        int id;
        int src;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    udma_ch_evt_decoder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_lin_done_i (pv[11:0]),
        .tx_lin_done_i (pv[30:12]),
        .rx_ext_done_i (pv[31:31]),
        .evt_valid_o   (evt_valid),
        .evt_ready_i   (rdy),
        .evt_id_o      (evt_id),
        .evt_src_o     (evt_src),
        .ovf_o         (ovf),
        .ovf_src_o     (ovf_src),
        .drop_cnt_o    (drop_cnt),
        .ovf_clr_i     (clr)
    );

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".valid"}, int'(evt_valid), int'(m_v));
        chk({tag, ".id"}, int'(evt_id), exp_ids[m_src]);
        chk({tag, ".src"}, int'(evt_src), m_src);
        chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
        chk({tag, ".ovf_src"}, int'(ovf_src), m_osrc);
        chk({tag, ".drop_cnt"}, int'(drop_cnt), m_cnt);
    endtask

    task automatic m_reset();
        m_pend = '0; m_v = 0; m_src = 0; m_ptr = 0; m_ovf = 0; m_osrc = 0; m_cnt = 0;
    endtask

    task automatic step(string tag);
        bit [31:0] clrv, hits;
        int w, n, lo;
        bit ld;
        ld = !m_v || rdy;
        w = -1;
        for (int i = 0; i < 32; i++) if (w < 0 && m_pend[(m_ptr + i) % 32]) w = (m_ptr + i) % 32;
        clrv = '0;
        if (ld && w >= 0) clrv[w] = 1'b1;
        hits = pv & m_pend & ~clrv;
        if (clr) begin m_ovf = 0; m_osrc = 0; m_cnt = 0; end
        n = $countones(hits);
        if (n > 0) begin
            lo = 0;
            for (int i = 31; i >= 0; i--) if (hits[i]) lo = i;
            if (!m_ovf) m_osrc = lo;
            m_ovf = 1;
            m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
        end
        m_pend = (m_pend & ~clrv) | pv;
        if (ld) begin
            m_v = (w >= 0);
            if (w >= 0) begin m_src = w; m_ptr = (w + 1) % 32; end
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; pv = '0; clr = 1'b0;
        @(posedge clk); #1;
        m_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 8, 2};
        vecs[1] = '{18, 10, 18};
        vecs[2] = '{30, 49, 30};
        vecs[3] = '{31, 44, 31};
        vecs[4] = '{11, 48, 11};
        vecs[5] = '{12, 1, 12};
        vecs[6] = '{26, 26, 26};
        vecs[7] = '{10, 40, 10};

        m_reset();
        do_reset();
        rdy = 1'b1;
        foreach (vecs[k]) begin
            pv = 32'd1 << vecs[k].bitpos;
            step("vec_pulse");
            pv = '0;
            step("vec_evt");
            chk("vec_valid", int'(evt_valid), 1);
            chk("vec_id", int'(evt_id), vecs[k].id);
            chk("vec_src", int'(evt_src), vecs[k].src);
            step("vec_idle");
            chk("vec_drop", int'(evt_valid), 0);
        end

        do_reset();
        rdy = 1'b1;
        pv = '1;
        step("all_pulse");
        pv = '0;
        step("all_first");
        for (int k = 0; k < 32; k++) begin
            chk("all_valid", int'(evt_valid), 1);
            chk("all_src", int'(evt_src), k);
            step("all_next");
        end
        chk("all_done", int'(evt_valid), 0);
        chk("all_noovf", int'(ovf), 0);

        do_reset();
        rdy = 1'b0;
        pv = 32'd1; step("hold_p1");
        pv = '0;    step("hold_gap");
        pv = 32'd1; step("hold_p2");
        pv = 32'd1; step("hold_p3");
        pv = '0;    step("hold_idle");
        chk("hold_valid", int'(evt_valid), 1);
        chk("hold_id", int'(evt_id), 0);
        chk("hold_ovf", int'(ovf), 1);
        chk("hold_ovf_src", int'(ovf_src), 0);
        chk("hold_cnt", int'(drop_cnt), 1);
        clr = 1'b1; step("hold_clr");
        clr = 1'b0;
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_cnt", int'(drop_cnt), 0);

        do_reset();
        rdy = 1'b0;
        pv = 32'h30; step("re5_p");
        pv = '0;     step("re5_hold4");
        chk("re5_first", int'(evt_src), 4);
        rdy = 1'b1;
        pv = 32'h20; step("re5_accept");
        pv = '0;
        chk("re5_src_a", int'(evt_src), 5);
        step("re5_again");
        chk("re5_src_b", int'(evt_src), 5);
        chk("re5_valid_b", int'(evt_valid), 1);
        chk("re5_noovf", int'(ovf), 0);
        step("re5_end");

        do_reset();
        rdy = 1'b0;
        pv = 32'h8;
        for (int k = 0; k < 302; k++) step("sat");
        pv = '0;
        step("sat_idle");
        chk("sat_cnt", int'(drop_cnt), 255);
        chk("sat_ovf_src", int'(ovf_src), 3);

        rdy = 1'b1;
        pv = 32'h0f0f_0f0f; step("mid_p");
        pv = '0;            step("mid_run");
        rst = 1'b1; #2;
        chk("mid_valid", int'(evt_valid), 0);
        chk("mid_ovf", int'(ovf), 0);
        chk("mid_cnt", int'(drop_cnt), 0);
        @(posedge clk); #1;
        m_reset();
        check_all("mid_rst");
        rst = 1'b0;
        step("mid_after");

        for (int k = 0; k < 800; k++) begin
            pv  = $urandom & $urandom & $urandom;
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        pv = '0; clr = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 40; k++) step("drain");
        chk("drain_empty", int'(evt_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
